// File: rtl/line_buffer_feeder_if.sv
// Row-stream bus between the line buffer feeder, its image memory and the convolve consumer.
// The master modport is the feeder; the slave modport is the memory/consumer side.
interface line_buffer_feeder_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 6
);
  logic                 start;
  logic                 shift_buffer;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BIT_DEPTH-1:0] mem_data;
  logic [BIT_DEPTH-1:0] in_l1;
  logic [BIT_DEPTH-1:0] in_l2;
  logic [BIT_DEPTH-1:0] in_l3;
  logic                 out_valid;
  logic                 ready;
  logic                 row_done;
  logic                 frame_done;

  modport master (
    input  start, shift_buffer, mem_data,
    output mem_rd_en, mem_addr, in_l1, in_l2, in_l3, out_valid, ready, row_done, frame_done
  );

  modport slave (
    output start, shift_buffer, mem_data,
    input  mem_rd_en, mem_addr, in_l1, in_l2, in_l3, out_valid, ready, row_done, frame_done
  );
endinterface

// File: rtl/line_buffer_feeder.sv
// Producer side of the convolve row-stream: fills three circular line buffers from sync-read
// memory and serves one vertically aligned 3-pixel column per shift request, band by band.
module line_buffer_feeder #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int ADDR_W     = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  line_buffer_feeder_if.master bus
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int BT_W  = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [BT_W-1:0]  BAND_LAST = BT_W'(IMG_HEIGHT - 3);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;
  localparam logic [1:0] S_ADVANCE = 2'd3;

  // Circular successor of a line-buffer index in {0,1,2}.
  function automatic logic [1:0] next_sel(input logic [1:0] sel);
    logic [1:0] res;
    if (sel == 2'd2) begin
      res = 2'd0;
    end else begin
      res = sel + 2'd1;
    end
    return res;
  endfunction

  logic [BIT_DEPTH-1:0] line_q [3][IMG_WIDTH];

  logic [1:0]           state_q,      state_d;
  logic [COL_W-1:0]     col_q,        col_d;
  logic [BT_W-1:0]      band_top_q,   band_top_d;
  logic [1:0]           top_sel_q,    top_sel_d;
  logic [1:0]           rd_row_q,     rd_row_d;
  logic [COL_W-1:0]     rd_col_q,     rd_col_d;
  logic                 mem_rd_en_q,  mem_rd_en_d;
  logic [ADDR_W-1:0]    mem_addr_q,   mem_addr_d;
  logic                 wr_vld_q,     wr_vld_d;
  logic [1:0]           wr_row_q,     wr_row_d;
  logic [COL_W-1:0]     wr_col_q,     wr_col_d;
  logic [BIT_DEPTH-1:0] in_l1_q,      in_l1_d;
  logic [BIT_DEPTH-1:0] in_l2_q,      in_l2_d;
  logic [BIT_DEPTH-1:0] in_l3_q,      in_l3_d;
  logic                 out_valid_q,  out_valid_d;
  logic                 ready_q,      ready_d;
  logic                 row_done_q,   row_done_d;
  logic                 frame_done_q, frame_done_d;

  logic [1:0]           mid_sel_s;
  logic [1:0]           bot_sel_s;
  logic                 last_read_s;

  assign mid_sel_s = next_sel(top_sel_q);
  assign bot_sel_s = next_sel(mid_sel_s);
  // FILL reads three rows into buffers 0..2; ADVANCE reads one row into the retiring top buffer.
  assign last_read_s = (rd_col_q == COL_LAST) && ((state_q == S_ADVANCE) || (rd_row_q == 2'd2));

  // Next-state logic for the sequencer, read counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    band_top_d   = band_top_q;
    top_sel_d    = top_sel_q;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    mem_rd_en_d  = mem_rd_en_q;
    mem_addr_d   = mem_addr_q;
    wr_vld_d     = mem_rd_en_q;
    wr_row_d     = rd_row_q;
    wr_col_d     = rd_col_q;
    in_l1_d      = in_l1_q;
    in_l2_d      = in_l2_q;
    in_l3_d      = in_l3_q;
    out_valid_d  = 1'b0;
    ready_d      = ready_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_FILL;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = '0;
          rd_row_d    = 2'd0;
          rd_col_d    = '0;
          col_d       = '0;
          band_top_d  = '0;
          top_sel_d   = 2'd0;
        end else begin
          mem_rd_en_d = 1'b0;
        end
      end

      S_FILL, S_ADVANCE: begin
        if (mem_rd_en_q) begin
          if (last_read_s) begin
            mem_rd_en_d = 1'b0;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            if (rd_col_q == COL_LAST) begin
              rd_col_d = '0;
              rd_row_d = rd_row_q + 2'd1;
            end else begin
              rd_col_d = rd_col_q + COL_W'(1);
            end
          end
        end else begin
          // Drain cycle: the final read's data is written this edge.
          state_d = S_READY;
          ready_d = 1'b1;
          if (state_q == S_ADVANCE) begin
            top_sel_d  = mid_sel_s;
            band_top_d = band_top_q + BT_W'(1);
          end else begin
            top_sel_d  = top_sel_q;
          end
        end
      end

      S_READY: begin
        if (bus.shift_buffer) begin
          in_l1_d     = line_q[top_sel_q][col_q];
          in_l2_d     = line_q[mid_sel_s][col_q];
          in_l3_d     = line_q[bot_sel_s][col_q];
          out_valid_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d      = '0;
            row_done_d = 1'b1;
            ready_d    = 1'b0;
            if (band_top_q == BAND_LAST) begin
              frame_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              // Next row continues the row-major address sequence.
              state_d     = S_ADVANCE;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = mem_addr_q + ADDR_W'(1);
              rd_row_d    = top_sel_q;
              rd_col_d    = '0;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          col_d = col_q;
        end
      end

      default: begin
        state_d     = S_IDLE;
        ready_d     = 1'b0;
        mem_rd_en_d = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      band_top_q   <= '0;
      top_sel_q    <= 2'd0;
      rd_row_q     <= 2'd0;
      rd_col_q     <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      wr_vld_q     <= 1'b0;
      wr_row_q     <= 2'd0;
      wr_col_q     <= '0;
      in_l1_q      <= '0;
      in_l2_q      <= '0;
      in_l3_q      <= '0;
      out_valid_q  <= 1'b0;
      ready_q      <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      band_top_q   <= band_top_d;
      top_sel_q    <= top_sel_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      wr_vld_q     <= wr_vld_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      in_l1_q      <= in_l1_d;
      in_l2_q      <= in_l2_d;
      in_l3_q      <= in_l3_d;
      out_valid_q  <= out_valid_d;
      ready_q      <= ready_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk_i) begin
    if (wr_vld_q) begin
      line_q[wr_row_q][wr_col_q] <= bus.mem_data;
    end
  end

  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.in_l1      = in_l1_q;
  assign bus.in_l2      = in_l2_q;
  assign bus.in_l3      = in_l3_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ready      = ready_q;
  assign bus.row_done   = row_done_q;
  assign bus.frame_done = frame_done_q;
endmodule
